// File: rtl/sal_axi_pkg.sv
// Shared types and helpers for the SAL AXI write front end.
package sal_axi_pkg;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespSlverr = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StDrain,
    StResp
  } wr_state_e;

  // log2 of the bus width in bytes; width is a power of two >= 8.
  function automatic int unsigned log2_bytes(input int unsigned width);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 28; i++) begin
      if ((32'd8 << i) == width) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/sal_axi_beat_addr_gen.sv
// Per-beat address step: FIXED holds the address, INCR aligns down to the
// beat size and advances one beat (wraps modulo 2^ADDR_WIDTH).
module sal_axi_beat_addr_gen
  import sal_axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] cur_addr,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] step;

  always_comb begin
    step      = ADDR_WIDTH'(1) << size;
    next_addr = cur_addr;
    if (burst == BurstIncr) begin
      next_addr = (cur_addr & ~(step - ADDR_WIDTH'(1))) + step;
    end
  end

endmodule

// File: rtl/sal_axi_wr_frontend.sv
// AXI write front end: splits one AW/W burst at a time into per-beat requests
// for the controller queue and returns the B response.
module sal_axi_wr_frontend
  import sal_axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_LEN   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    awvalid,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [ADDR_LEN-1:0]     awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  output logic                    awready,
  input  logic                    wvalid,
  input  logic [ID_WIDTH-1:0]     wid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  output logic                    wready,
  output logic                    bvalid,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  input  logic                    bready,
  output logic                    req_valid,
  output logic [ADDR_WIDTH-1:0]   req_addr,
  output logic [ID_WIDTH-1:0]     req_id,
  output logic [DATA_WIDTH-1:0]   req_data,
  output logic [DATA_WIDTH/8-1:0] req_strb,
  output logic                    req_last,
  input  logic                    req_ready
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;
  localparam logic [2:0]  MaxSize   = 3'(log2_bytes(DATA_WIDTH));

  wr_state_e state_q, state_d;

  logic                  awready_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_LEN-1:0]   len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [ADDR_LEN-1:0]   beat_cnt_q;
  logic                  skip_q;
  logic                  err_q, err_d;

  logic                  req_valid_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [ID_WIDTH-1:0]   req_id_q;
  logic [DATA_WIDTH-1:0] req_data_q;
  logic [StrbWidth-1:0]  req_strb_q;
  logic                  req_last_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [1:0]            bresp_q;

  logic                  aw_hs, w_hs, req_hs, last_beat, skip_new, id_match;
  logic [ADDR_WIDTH-1:0] next_addr;

  sal_axi_beat_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .cur_addr (addr_q),
    .size     (size_q),
    .burst    (burst_q),
    .next_addr(next_addr)
  );

  always_comb begin
    aw_hs     = awvalid && awready_q && (state_q == StIdle);
    // One-entry output register: a new beat may enter as the old one leaves.
    wready    = (state_q == StData) && (!req_valid_q || req_ready);
    w_hs      = wvalid && wready;
    req_hs    = req_valid_q && req_ready;
    last_beat = (beat_cnt_q == len_q);
    id_match  = (wid == id_q);
    skip_new  = ((awburst != BurstIncr) && (awburst != BurstFixed)) || (awsize > MaxSize);
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (aw_hs) begin
          state_d = StData;
          err_d   = skip_new;
        end
      end
      StData: begin
        if (w_hs) begin
          if (!skip_q && !id_match) err_d = 1'b1;
          if (wlast != last_beat)   err_d = 1'b1;
          // The beat count, not wlast, closes the burst.
          if (last_beat) state_d = skip_q ? StResp : StDrain;
        end
      end
      StDrain: begin
        if (req_hs) state_d = StResp;
      end
      StResp: begin
        if (bready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      awready_q   <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      beat_cnt_q  <= '0;
      skip_q      <= 1'b0;
      err_q       <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_id_q    <= '0;
      req_data_q  <= '0;
      req_strb_q  <= '0;
      req_last_q  <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      awready_q <= (state_d == StIdle);

      if (aw_hs) begin
        id_q       <= awid;
        addr_q     <= awaddr;
        len_q      <= awlen;
        size_q     <= awsize;
        burst_q    <= awburst;
        skip_q     <= skip_new;
        beat_cnt_q <= '0;
      end

      if (w_hs) begin
        beat_cnt_q <= beat_cnt_q + ADDR_LEN'(1);
        addr_q     <= next_addr;
      end

      if (w_hs && !skip_q) begin
        req_valid_q <= 1'b1;
        req_addr_q  <= addr_q;
        req_id_q    <= id_q;
        req_data_q  <= wdata;
        req_strb_q  <= id_match ? wstrb : '0;
        req_last_q  <= last_beat;
      end else if (req_hs) begin
        req_valid_q <= 1'b0;
      end

      if ((state_d == StResp) && (state_q != StResp)) begin
        bid_q   <= id_q;
        bresp_q <= err_d ? RespSlverr : RespOkay;
      end
    end
  end

  assign awready   = awready_q;
  assign bvalid    = (state_q == StResp);
  assign bid       = bid_q;
  assign bresp     = bresp_q;
  assign req_valid = req_valid_q;
  assign req_addr  = req_addr_q;
  assign req_id    = req_id_q;
  assign req_data  = req_data_q;
  assign req_strb  = req_strb_q;
  assign req_last  = req_last_q;

endmodule

// File: tb/tb_sal_axi_wr_frontend.sv
// Scoreboard bench for sal_axi_wr_frontend: directed bursts plus random ones.
module tb_sal_axi_wr_frontend;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awvalid = 1'b0;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [3:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awready;
  logic        wvalid = 1'b0;
  logic [3:0]  wid = '0;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wready;
  logic        bvalid;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bready = 1'b1;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [3:0]  req_id;
  logic [63:0] req_data;
  logic [7:0]  req_strb;
  logic        req_last;
  logic        req_ready = 1'b1;

  sal_axi_wr_frontend #(
    .ADDR_WIDTH(32),
    .ID_WIDTH  (4),
    .DATA_WIDTH(64),
    .ADDR_LEN  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .awvalid  (awvalid),
    .awid     (awid),
    .awaddr   (awaddr),
    .awlen    (awlen),
    .awsize   (awsize),
    .awburst  (awburst),
    .awready  (awready),
    .wvalid   (wvalid),
    .wid      (wid),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wlast    (wlast),
    .wready   (wready),
    .bvalid   (bvalid),
    .bid      (bid),
    .bresp    (bresp),
    .bready   (bready),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_id   (req_id),
    .req_data (req_data),
    .req_strb (req_strb),
    .req_last (req_last),
    .req_ready(req_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int rr_mode = 0;      // 0: ready always, 1: toggle, 2: random
  bit br_rand = 1'b0;
  bit mon_en = 1'b1;

  logic [108:0] exp_req[$];  // {addr, id, data, strb, last}
  logic [5:0]   exp_b[$];    // {id, resp}

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Downstream and B-channel ready generators.
  initial forever begin
    @(posedge clk);
    #1;
    case (rr_mode)
      0:       req_ready = 1'b1;
      1:       req_ready = ~req_ready;
      default: req_ready = 1'($urandom_range(0, 1));
    endcase
    bready = br_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard on each observed handshake.
  logic         stalled;
  logic [108:0] held;
  logic [108:0] got;
  logic [108:0] e;
  logic [5:0]   eb;
  initial begin
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      got = {req_addr, req_id, req_data, req_strb, req_last};
      if (!mon_en || rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) chk("req_hold", {req_valid, got}, {1'b1, held});
        if (req_valid && req_ready) begin
          if (exp_req.size() == 0) fail("unexpected_req");
          else begin
            e = exp_req.pop_front();
            chk("req_payload", got, e);
          end
        end
        if (bvalid && bready) begin
          if (exp_b.size() == 0) fail("unexpected_b");
          else begin
            eb = exp_b.pop_front();
            chk("b_resp", {bid, bresp}, eb);
          end
        end
        stalled = req_valid && !req_ready;
        held    = got;
      end
    end
  end

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst);
    logic [31:0] step;
    step = 32'd1 << size;
    if (burst == 2'b01) return (a / step) * step + step;
    return a;
  endfunction

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit ok = 1'b0;
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (awready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    awvalid = 1'b0;
    if (!ok) fail("aw_timeout");
    else chk("awready_drop", awready, 0);
  endtask

  task automatic send_w(input logic [3:0] id, input logic [63:0] d, input logic [7:0] s,
                        input logic l);
    bit ok = 1'b0;
    wvalid = 1'b1; wid = id; wdata = d; wstrb = s; wlast = l;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (wready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    wvalid = 1'b0;
    if (!ok) fail("w_timeout");
  endtask

  // Reference model pushes expectations, then the burst is driven.
  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int bad_wid_beat, input int bad_last_beat, input int max_gap);
    logic [63:0] d[16];
    logic [7:0]  s[16];
    logic [3:0]  w[16];
    logic        l[16];
    logic [31:0] a;
    bit          skip, err;
    skip = (burst == 2'b10) || (burst == 2'b11) || (size > 3'd3);
    err  = skip;
    a    = addr;
    for (int i = 0; i <= int'(len); i++) begin
      d[i] = {$urandom, $urandom};
      s[i] = 8'($urandom);
      w[i] = (i == bad_wid_beat) ? (id ^ 4'h9) : id;
      l[i] = (i == int'(len)) ^ (i == bad_last_beat);
      if (!skip) begin
        if (w[i] != id) err = 1'b1;
        exp_req.push_back({a, id, d[i], (w[i] == id) ? s[i] : 8'h00, i == int'(len)});
      end
      if (l[i] != (i == int'(len))) err = 1'b1;
      a = next_addr(a, size, burst);
    end
    exp_b.push_back({id, err ? 2'b10 : 2'b00});
    send_aw(id, addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      repeat ($urandom_range(0, max_gap)) @(posedge clk);
      #1;
      send_w(w[i], d[i], s[i], l[i]);
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (exp_req.size() == 0 && exp_b.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {awready, wready, bvalid, req_valid, bid, bresp},
        {4'b0000, 4'h0, 2'b00});
    chk("reset_payload", {req_addr, req_id, req_data, req_strb, req_last}, '0);
    rst = 1'b0;
    chk("awready_pre", awready, 0);
    @(posedge clk);
    #1;
    chk("awready_post_reset", awready, 1);

    // Aligned INCR, full-rate.
    run_burst(4'd3, 32'h100, 4'd3, 3'd3, 2'b01, -1, -1, 0);
    wait_idle();
    // Unaligned INCR start.
    run_burst(4'd1, 32'h105, 4'd2, 3'd2, 2'b01, -1, -1, 0);
    wait_idle();
    // FIXED with toggling downstream ready.
    rr_mode = 1;
    run_burst(4'd2, 32'h40, 4'd1, 3'd3, 2'b00, -1, -1, 0);
    wait_idle();
    rr_mode = 0;
    // WRAP is rejected: beats consumed, nothing forwarded.
    run_burst(4'd7, 32'h80, 4'd3, 3'd3, 2'b10, -1, -1, 0);
    wait_idle();
    // Early wlast on beat 0, wrong wid on beat 1.
    run_burst(4'd5, 32'h200, 4'd1, 3'd3, 2'b01, 1, 0, 0);
    wait_idle();

    // Reset mid-burst after beat 1 of a 4-beat burst.
    mon_en = 1'b0;
    send_aw(4'd6, 32'h300, 4'd3, 3'd3, 2'b01);
    send_w(4'd6, 64'h11, 8'hff, 1'b0);
    send_w(4'd6, 64'h22, 8'hff, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_req_valid", req_valid, 0);
    chk("rst_mid_bvalid", bvalid, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_awready", awready, 1);
    mon_en = 1'b1;
    run_burst(4'd9, 32'h400, 4'd2, 3'd3, 2'b01, -1, -1, 0);
    wait_idle();

    // Random bursts with random back-pressure.
    rr_mode = 2;
    br_rand = 1'b1;
    for (int n = 0; n < 60; n++) begin
      logic [1:0] bt;
      logic [2:0] sz;
      int         bw, bl;
      bt = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      bw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : -1;
      bl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : -1;
      run_burst(4'($urandom), $urandom, 4'($urandom), sz, bt, bw, bl, 2);
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
